tape_ear_conditioner: RTL and testbench
=======================================

// Module: tape_ear_conditioner
// PURPOSE
//  Cleans the raw EAR comparator bit from the LTC2308 tape ADC and produces the
//  tape-in level consumed by the lynx48 core. Sits between ltc2308_tape (dout/active)
//  and the lynx48 EAR input. Adds synchronisation, glitch filtering, edge strobes,
//  pulse-period measurement and activity detection for the LED.
// PARAMETERS
//  FILTER_LEN   8      consecutive stable clocks before a level change is accepted (2..255)
//  PRESCALE     16     clock cycles per period-counter tick (>=1)
//  IDLE_TICKS   65535  prescaled ticks without an accepted edge before the stream is deemed idle
// PORTS
//  clock       in   1   system clock (clk_sys)
//  reset_osd   in   1   asynchronous active-low reset
//  adc_in      in   1   raw comparator bit (ltc2308_tape dout); asynchronous to clock
//  adc_act     in   1   ADC active flag (ltc2308_tape active); asynchronous to clock
//  invert      in   1   OSD option: invert tape polarity; quasi-static
//  ear         out  1   filtered tape level to lynx48
//  edge_stb    out  1   one-clock pulse per accepted transition of ear
//  period      out  16  prescaled ticks between the last two accepted edges (saturates 0xFFFF)
//  period_vld  out  1   one-clock pulse when period updates
//  active      out  1   1 while edges arrive within IDLE_TICKS
//  led         out  1   tape activity LED (to LED_USER mux)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, all counters 0, sync flops 0.
//  - Sync: adc_in and adc_act each pass a 2-flop synchroniser -> in_s, act_s.
//    cand = in_s ^ invert.
//  - Filter: flt_cnt counts clocks with cand != ear; cleared whenever cand == ear.
//    When flt_cnt reaches FILTER_LEN-1 with cand != ear: ear <= cand, edge_stb <= 1,
//    flt_cnt <= 0. Input-to-ear latency = 2 + FILTER_LEN clocks. Pulses shorter than
//    FILTER_LEN clocks are discarded entirely.
//  - invert toggling is treated as an input change: ear flips FILTER_LEN clocks later.
//  - FSM states IDLE / ARMED / RUN:
//    IDLE : ear forced 0, filter and counters cleared, active=0. act_s=1 -> ARMED.
//    ARMED: filter runs; active=0. First accepted edge -> RUN, tick counter cleared,
//           no period_vld for this edge.
//    RUN  : active=1. Each accepted edge: period <= tick_cnt, period_vld=1 for one
//           clock, tick_cnt <= 0, idle_cnt <= 0. tick_cnt increments every PRESCALE
//           clocks and saturates at 0xFFFF. idle_cnt reaching IDLE_TICKS -> ARMED
//           (period holds last value).
//    Any state: act_s=0 -> IDLE next clock (ear drops to 0, period holds).
//  - Simultaneous accepted edge and idle timeout: edge wins, stay in RUN.
//  - Simultaneous act_s fall and accepted edge: IDLE wins, no strobes emitted.
//  - Prescaler free-runs from reset; period quantisation error is <=1 tick.
//  - led = active & ear (blinks with the tape signal); 0 outside RUN.
//  - edge_stb and period_vld registered; never high for more than one clock.
// CONFIGURATION
//  TAPE_MONITOR_EN defined: adds port  monitor  out  16  signed audio sample for mixing
//    into AUDIO_L/R: +16'sh0800 when ear=1, -16'sh0800 when ear=0, 0 when not active;
//    registered, updates one clock after ear/active.
//  TAPE_MONITOR_EN undefined: monitor port and its logic are absent; all other
//    behaviour identical.
// TESTING (FILTER_LEN=8, PRESCALE=16, IDLE_TICKS=100 in bench)
//  1 reset_osd=0 mid-RUN -> all outputs 0 immediately, FSM IDLE after release.
//  2 adc_act=1, adc_in 0->1 held -> ear=1 exactly 10 clocks after adc_in edge,
//    edge_stb single pulse, no period_vld (ARMED->RUN).
//  3 adc_in square wave, half-period 320 clocks -> period_vld every 320 clocks,
//    period=20 (+/-1), active=1, led follows ear.
//  4 adc_in 5-clock glitch high while ear=0 -> ear stays 0, no edge_stb.
//  5 stop toggling in RUN -> active=0 after 100 ticks (1600 clocks), period held;
//    resume toggling -> first edge gives no period_vld, second does.
//  6 adc_act drops during RUN -> ear=0 and active=0 within 3 clocks; with
//    TAPE_MONITOR_EN monitor=0x0800/0xF800 in RUN, 0 after drop.

Source files
------------

// File: rtl/tape_ear_conditioner.sv
// -----------------------------------------------------------------------------
// tape_ear_conditioner
//
// Cleans the raw EAR comparator bit from the LTC2308 tape ADC and produces the
// tape-in level for the lynx48 core. The block does five things:
//   - synchronises the comparator bit and the ADC-active flag,
//   - glitch-filters the level,
//   - emits an edge strobe,
//   - measures the pulse period in prescaled ticks,
//   - detects stream activity for the LED.
//
// Optional feature macro: TAPE_MONITOR_EN
//   When defined, adds a signed audio monitor output that can be mixed into
//   AUDIO_L/R. When undefined, the port and its logic are absent.
//
// Parameters
//   FILTER_LEN  consecutive stable clocks before a level change is accepted (2..255)
//   PRESCALE    clock cycles per period-counter tick (1..65536)
//   IDLE_TICKS  prescaled ticks without an accepted edge before the stream idles
//               (1..65535)
//
// Ports
//   clock       in   system clock (clk_sys)
//   reset_osd   in   asynchronous active-low reset
//   adc_in      in   raw comparator bit, asynchronous to clock
//   adc_act     in   ADC active flag, asynchronous to clock
//   invert      in   invert tape polarity (quasi-static OSD option)
//   ear         out  filtered tape level
//   edge_stb    out  one-clock pulse per accepted transition of ear
//   period      out  ticks between the last two accepted edges (saturating)
//   period_vld  out  one-clock pulse when period updates
//   active      out  1 while edges keep arriving within IDLE_TICKS
//   led         out  tape activity LED (active & ear)
//   monitor     out  signed audio sample (only with TAPE_MONITOR_EN)
// -----------------------------------------------------------------------------
module tape_ear_conditioner #(
  parameter int FILTER_LEN = 8,
  parameter int PRESCALE   = 16,
  parameter int IDLE_TICKS = 65535
) (
  input  logic        clock,
  input  logic        reset_osd,
  input  logic        adc_in,
  input  logic        adc_act,
  input  logic        invert,
  output logic        ear,
  output logic        edge_stb,
  output logic [15:0] period,
  output logic        period_vld,
  output logic        active,
  output logic        led
`ifdef TAPE_MONITOR_EN
  ,
  output logic signed [15:0] monitor
`endif
);

  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_ARMED   = 2'd1;
  localparam logic [1:0]  ST_RUN     = 2'd2;

  localparam logic [7:0]  FLT_LAST   = 8'(FILTER_LEN - 1);
  localparam logic [15:0] PRE_LAST   = 16'(PRESCALE - 1);
  localparam logic [15:0] IDLE_LIMIT = 16'(IDLE_TICKS);

  // Synchroniser flops.
  logic        in_meta_q;
  logic        in_sync_q;
  logic        act_meta_q;
  logic        act_sync_q;

  // Filter / FSM / measurement state.
  logic [1:0]  state_q,      state_d;
  logic        ear_q,        ear_d;
  logic [7:0]  flt_cnt_q,    flt_cnt_d;
  logic        edge_stb_q,   edge_stb_d;
  logic [15:0] period_q,     period_d;
  logic        period_vld_q, period_vld_d;
  logic [15:0] tick_cnt_q,   tick_cnt_d;
  logic [15:0] idle_cnt_q,   idle_cnt_d;
  logic        active_q,     active_d;
  logic        led_q,        led_d;
  logic [15:0] pre_cnt_q,    pre_cnt_d;

  // Combinational helpers.
  logic        cand_s;
  logic        differ_s;
  logic        accept_s;
  logic [7:0]  flt_next_s;
  logic        tick_s;

  // Saturating increment: the counter sticks at 0xFFFF instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic step);
    logic [15:0] res;
    if (step && (val != 16'hFFFF)) begin
      res = val + 16'd1;
    end else begin
      res = val;
    end
    return res;
  endfunction

  // Increment that stops at a limit; used for the idle timeout counter.
  function automatic logic [15:0] inc_to_limit(input logic [15:0] val, input logic step,
                                               input logic [15:0] limit);
    logic [15:0] res;
    if (step && (val < limit)) begin
      res = val + 16'd1;
    end else begin
      res = val;
    end
    return res;
  endfunction

  // Two-flop synchronisers for the asynchronous comparator bit and active flag.
  always_ff @(posedge clock or negedge reset_osd) begin
    if (!reset_osd) begin
      in_meta_q  <= 1'b0;
      in_sync_q  <= 1'b0;
      act_meta_q <= 1'b0;
      act_sync_q <= 1'b0;
    end else begin
      in_meta_q  <= adc_in;
      in_sync_q  <= in_meta_q;
      act_meta_q <= adc_act;
      act_sync_q <= act_meta_q;
    end
  end

  // Glitch filter: count the clocks during which the candidate disagrees with ear.
  // invert is applied here, so toggling it looks like an input change.
  always_comb begin
    cand_s     = in_sync_q ^ invert;
    differ_s   = (cand_s != ear_q);
    accept_s   = 1'b0;
    flt_next_s = 8'd0;
    if (differ_s) begin
      if (flt_cnt_q == FLT_LAST) begin
        accept_s   = 1'b1;
        flt_next_s = 8'd0;
      end else begin
        accept_s   = 1'b0;
        flt_next_s = flt_cnt_q + 8'd1;
      end
    end else begin
      accept_s   = 1'b0;
      flt_next_s = 8'd0;
    end
  end

  // Free-running prescaler; tick_s marks the last clock of each tick period.
  always_comb begin
    tick_s = (pre_cnt_q == PRE_LAST);
    if (tick_s) begin
      pre_cnt_d = 16'd0;
    end else begin
      pre_cnt_d = pre_cnt_q + 16'd1;
    end
  end

  // Main FSM: filter acceptance, period measurement and idle timeout.
  always_comb begin
    state_d      = state_q;
    ear_d        = ear_q;
    flt_cnt_d    = flt_cnt_q;
    edge_stb_d   = 1'b0;
    period_d     = period_q;
    period_vld_d = 1'b0;
    tick_cnt_d   = tick_cnt_q;
    idle_cnt_d   = idle_cnt_q;

    case (state_q)
      ST_IDLE: begin
        ear_d      = 1'b0;
        flt_cnt_d  = 8'd0;
        tick_cnt_d = 16'd0;
        idle_cnt_d = 16'd0;
        if (act_sync_q) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        flt_cnt_d  = flt_next_s;
        tick_cnt_d = 16'd0;
        idle_cnt_d = 16'd0;
        if (accept_s) begin
          // The first edge only starts the measurement; no period for it.
          ear_d      = cand_s;
          edge_stb_d = 1'b1;
          state_d    = ST_RUN;
        end else begin
          state_d    = ST_ARMED;
        end
      end
      ST_RUN: begin
        flt_cnt_d  = flt_next_s;
        tick_cnt_d = sat_inc16(tick_cnt_q, tick_s);
        idle_cnt_d = inc_to_limit(idle_cnt_q, tick_s, IDLE_LIMIT);
        if (accept_s) begin
          // A tick landing on the edge clock is counted, so a whole number of
          // tick periods between edges is reported exactly. An edge also
          // overrides a simultaneous idle timeout.
          ear_d        = cand_s;
          edge_stb_d   = 1'b1;
          period_d     = sat_inc16(tick_cnt_q, tick_s);
          period_vld_d = 1'b1;
          tick_cnt_d   = 16'd0;
          idle_cnt_d   = 16'd0;
          state_d      = ST_RUN;
        end else if (idle_cnt_q == IDLE_LIMIT) begin
          state_d      = ST_ARMED;
        end else begin
          state_d      = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        ear_d      = 1'b0;
        flt_cnt_d  = 8'd0;
        tick_cnt_d = 16'd0;
        idle_cnt_d = 16'd0;
      end
    endcase

    // Loss of ADC activity beats everything, including an edge on the same clock.
    if (!act_sync_q) begin
      state_d      = ST_IDLE;
      ear_d        = 1'b0;
      flt_cnt_d    = 8'd0;
      edge_stb_d   = 1'b0;
      period_d     = period_q;
      period_vld_d = 1'b0;
      tick_cnt_d   = 16'd0;
      idle_cnt_d   = 16'd0;
    end else begin
      state_d      = state_d;
    end
  end

  // Derived status outputs, computed from next-state so they register alongside it.
  always_comb begin
    active_d = (state_d == ST_RUN);
    led_d    = active_d & ear_d;
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_osd) begin
    if (!reset_osd) begin
      state_q      <= ST_IDLE;
      ear_q        <= 1'b0;
      flt_cnt_q    <= 8'd0;
      edge_stb_q   <= 1'b0;
      period_q     <= 16'd0;
      period_vld_q <= 1'b0;
      tick_cnt_q   <= 16'd0;
      idle_cnt_q   <= 16'd0;
      active_q     <= 1'b0;
      led_q        <= 1'b0;
      pre_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      ear_q        <= ear_d;
      flt_cnt_q    <= flt_cnt_d;
      edge_stb_q   <= edge_stb_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      tick_cnt_q   <= tick_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      active_q     <= active_d;
      led_q        <= led_d;
      pre_cnt_q    <= pre_cnt_d;
    end
  end

  assign ear        = ear_q;
  assign edge_stb   = edge_stb_q;
  assign period     = period_q;
  assign period_vld = period_vld_q;
  assign active     = active_q;
  assign led        = led_q;

`ifdef TAPE_MONITOR_EN
  localparam logic signed [15:0] MON_HIGH = 16'sh0800;
  localparam logic signed [15:0] MON_LOW  = 16'shF800;

  logic signed [15:0] monitor_q, monitor_d;

  // Audio monitor sample: follows the registered ear/active one clock later.
  always_comb begin
    if (active_q) begin
      if (ear_q) begin
        monitor_d = MON_HIGH;
      end else begin
        monitor_d = MON_LOW;
      end
    end else begin
      monitor_d = 16'sh0000;
    end
  end

  // Monitor sample register.
  always_ff @(posedge clock or negedge reset_osd) begin
    if (!reset_osd) begin
      monitor_q <= 16'sh0000;
    end else begin
      monitor_q <= monitor_d;
    end
  end

  assign monitor = monitor_q;
`endif

endmodule

// File: tb/tb_tape_ear_conditioner.sv
module tb_tape_ear_conditioner;

  localparam int FL = 8;
  localparam int PS = 16;
  localparam int IT = 100;

  logic        clock     = 1'b0;
  logic        reset_osd = 1'b0;
  logic        adc_in    = 1'b0;
  logic        adc_act   = 1'b0;
  logic        invert    = 1'b0;
  logic        ear, edge_stb, period_vld, active, led;
  logic [15:0] period;
`ifdef TAPE_MONITOR_EN
  logic signed [15:0] monitor;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  tape_ear_conditioner #(
    .FILTER_LEN (FL),
    .PRESCALE   (PS),
    .IDLE_TICKS (IT)
  ) dut (
    .clock      (clock),
    .reset_osd  (reset_osd),
    .adc_in     (adc_in),
    .adc_act    (adc_act),
    .invert     (invert),
    .ear        (ear),
    .edge_stb   (edge_stb),
    .period     (period),
    .period_vld (period_vld),
    .active     (active),
    .led        (led)
`ifdef TAPE_MONITOR_EN
    ,
    .monitor    (monitor)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model. Time is measured as a clock index since reset release;
  // ticks fall on every PS-th clock, so tick counts over an interval are
  // plain integer division. Filtering is the rule "cand has disagreed with
  // ear for FL clocks in a row".
  // ---------------------------------------------------------------------------
  typedef enum int {M_IDLE, M_ARMED, M_RUN} mode_t;
  mode_t              m_mode   = M_IDLE;
  bit                 m_ear    = 1'b0;
  bit                 m_edge   = 1'b0;
  bit                 m_pvld   = 1'b0;
  bit                 m_active = 1'b0;
  bit                 m_led    = 1'b0;
  bit [15:0]          m_period = 16'd0;
  bit [1:0]           m_in_pipe  = 2'b00;
  bit [1:0]           m_act_pipe = 2'b00;
  int                 m_differ = 0;
  longint             m_cyc    = 0;
  longint             m_last   = 0;
  logic signed [15:0] m_mon    = 16'sh0000;

  function automatic longint ticks_upto(input longint c);
    return (c + 64'sd1) / PS;
  endfunction

  always @(posedge clock or negedge reset_osd) begin : ref_model
    bit     in_s;
    bit     act_s;
    bit     cand;
    longint n;
    if (!reset_osd) begin
      m_mode = M_IDLE; m_ear = 1'b0; m_edge = 1'b0; m_pvld = 1'b0;
      m_active = 1'b0; m_led = 1'b0; m_period = 16'd0;
      m_in_pipe = 2'b00; m_act_pipe = 2'b00; m_differ = 0;
      m_cyc = 0; m_last = 0; m_mon = 16'sh0000;
    end else begin
      in_s       = m_in_pipe[1];
      act_s      = m_act_pipe[1];
      m_in_pipe  = {m_in_pipe[0], adc_in};
      m_act_pipe = {m_act_pipe[0], adc_act};
      cand       = in_s ^ invert;
      m_mon      = m_active ? (m_ear ? 16'sh0800 : 16'shF800) : 16'sh0000;
      m_edge     = 1'b0;
      m_pvld     = 1'b0;
      if (!act_s) begin
        m_mode = M_IDLE; m_ear = 1'b0; m_differ = 0;
      end else if (m_mode == M_IDLE) begin
        m_mode = M_ARMED; m_ear = 1'b0; m_differ = 0;
      end else begin
        if (cand != m_ear) m_differ++;
        else m_differ = 0;
        if (m_differ == FL) begin
          m_differ = 0;
          m_ear    = cand;
          m_edge   = 1'b1;
          if (m_mode == M_RUN) begin
            n        = ticks_upto(m_cyc) - ticks_upto(m_last);
            m_period = (n > 65535) ? 16'hFFFF : 16'(n);
            m_pvld   = 1'b1;
          end
          m_mode = M_RUN;
          m_last = m_cyc;
        end else if (m_mode == M_RUN &&
                     (ticks_upto(m_cyc - 1) - ticks_upto(m_last)) >= IT) begin
          m_mode = M_ARMED;
        end
      end
      m_active = (m_mode == M_RUN);
      m_led    = m_active & m_ear;
      m_cyc++;
    end
  end

  logic [20:0] got_v, exp_v;
  assign got_v = {ear, edge_stb, period, period_vld, active, led};
  assign exp_v = {m_ear, m_edge, m_period, m_pvld, m_active, m_led};

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_osd = 1'b0; adc_act = 1'b0; adc_in = 1'b0; invert = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++;
    if (got_v !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got %h exp %h", got_v, 21'd0);
    end
    reset_osd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL reset_lockstep got %h exp %h", got_v, exp_v);
      end
    end
  endtask

  task automatic test_arm_edge();
    int first_hi = 0;
    int n_edge   = 0;
    int n_vld    = 0;
    adc_act = 1'b1;
    repeat (6) begin
      @(negedge clock);
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL arm_lockstep got %h exp %h", got_v, exp_v);
      end
    end
    adc_in = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL arm_edge_lockstep got %h exp %h", got_v, exp_v);
      end
      if (ear === 1'b1 && first_hi == 0) first_hi = k;
      if (edge_stb === 1'b1) n_edge++;
      if (period_vld === 1'b1) n_vld++;
    end
    tests_run++;
    if (first_hi != 2 + FL) begin
      tests_failed++;
      $display("FAIL arm_latency got %0d exp %0d", first_hi, 2 + FL);
    end
    tests_run++;
    if (n_edge != 1 || n_vld != 0) begin
      tests_failed++;
      $display("FAIL arm_strobes edges %0d vld %0d exp 1 0", n_edge, n_vld);
    end
  endtask

  task automatic test_square();
    int n_vld;
    for (int h = 0; h < 8; h++) begin
      adc_in = ~adc_in;
      n_vld  = 0;
      for (int j = 0; j < 320; j++) begin
        @(negedge clock);
        tests_run++;
        if (got_v !== exp_v) begin
          tests_failed++;
          $display("FAIL square_lockstep got %h exp %h", got_v, exp_v);
        end
        if (period_vld === 1'b1) begin
          n_vld++;
          if (h > 0) begin
            tests_run++;
            if (period < 16'd19 || period > 16'd21) begin
              tests_failed++;
              $display("FAIL square_period got %0d exp 20", period);
            end
          end
        end
      end
      tests_run++;
      if (n_vld != 1 || active !== 1'b1 || led !== ear) begin
        tests_failed++;
        $display("FAIL square_window vld %0d active %b led %b ear %b", n_vld, active, led, ear);
      end
    end
  endtask

  task automatic test_glitch();
    int n_edge;
    int widths [3] = '{5, FL - 1, FL};
    adc_in = 1'b0;
    repeat (40) begin
      @(negedge clock);
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL glitch_lockstep got %h exp %h", got_v, exp_v);
      end
    end
    for (int w = 0; w < 3; w++) begin
      n_edge = 0;
      adc_in = 1'b1;
      for (int j = 0; j < widths[w] + 30; j++) begin
        if (j == widths[w]) adc_in = 1'b0;
        @(negedge clock);
        tests_run++;
        if (got_v !== exp_v) begin
          tests_failed++;
          $display("FAIL glitch_lockstep w%0d got %h exp %h", widths[w], got_v, exp_v);
        end
        if (edge_stb === 1'b1) n_edge++;
      end
      tests_run++;
      if (n_edge != ((widths[w] >= FL) ? 2 : 0) || ear !== 1'b0) begin
        tests_failed++;
        $display("FAIL glitch_width%0d edges %0d ear %b", widths[w], n_edge, ear);
      end
    end
  endtask

  task automatic test_idle();
    logic [15:0] held;
    int k = 0;
    int n_vld = 0;
    int n_edge = 0;
    adc_in = 1'b1;
    repeat (20) begin
      @(negedge clock);
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL idle_lockstep got %h exp %h", got_v, exp_v);
      end
      if (edge_stb === 1'b1) k = 1;
    end
    held = period;
    k = 20 - (2 + FL);
    while (active === 1'b1 && k < 2000) begin
      @(negedge clock);
      k++;
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL idle_lockstep got %h exp %h", got_v, exp_v);
      end
      if (period_vld === 1'b1) n_vld++;
    end
    tests_run++;
    if (k < 1584 || k > 1602 || period !== held || n_vld != 0) begin
      tests_failed++;
      $display("FAIL idle_timeout clocks %0d period %0d held %0d vld %0d", k, period, held, n_vld);
    end
    for (int r = 0; r < 2; r++) begin
      adc_in = ~adc_in;
      n_vld = 0; n_edge = 0;
      repeat (320) begin
        @(negedge clock);
        tests_run++;
        if (got_v !== exp_v) begin
          tests_failed++;
          $display("FAIL resume_lockstep got %h exp %h", got_v, exp_v);
        end
        if (period_vld === 1'b1) n_vld++;
        if (edge_stb === 1'b1) n_edge++;
      end
      tests_run++;
      if (n_edge != 1 || n_vld != r || active !== 1'b1) begin
        tests_failed++;
        $display("FAIL resume_edge%0d edges %0d vld %0d active %b", r, n_edge, n_vld, active);
      end
    end
  endtask

  task automatic test_act_drop();
    logic [15:0] held = period;
`ifdef TAPE_MONITOR_EN
    tests_run++;
    if (monitor !== (ear ? 16'sh0800 : 16'shF800)) begin
      tests_failed++;
      $display("FAIL monitor_run got %h ear %b", monitor, ear);
    end
`endif
    adc_act = 1'b0;
    repeat (3) begin
      @(negedge clock);
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL drop_lockstep got %h exp %h", got_v, exp_v);
      end
    end
    tests_run++;
    if (ear !== 1'b0 || active !== 1'b0 || led !== 1'b0 || period !== held) begin
      tests_failed++;
      $display("FAIL act_drop ear %b active %b led %b period %0d held %0d", ear, active, led, period, held);
    end
    @(negedge clock);
`ifdef TAPE_MONITOR_EN
    tests_run++;
    if (monitor !== 16'sh0000) begin
      tests_failed++;
      $display("FAIL monitor_drop got %h exp 0000", monitor);
    end
`endif
  endtask

  task automatic test_invert();
    int flip_at;
    adc_act = 1'b1; adc_in = 1'b0; invert = 1'b0;
    repeat (20) @(negedge clock);
    for (int r = 0; r < 2; r++) begin
      invert  = ~invert;
      flip_at = 0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clock);
        tests_run++;
        if (got_v !== exp_v) begin
          tests_failed++;
          $display("FAIL invert_lockstep got %h exp %h", got_v, exp_v);
        end
        if (ear === invert && flip_at == 0) flip_at = k;
      end
      tests_run++;
      if (flip_at != FL) begin
        tests_failed++;
        $display("FAIL invert_latency got %0d exp %0d", flip_at, FL);
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    int r;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      tests_run++;
      if (got_v !== exp_v) begin
        tests_failed++;
        $display("FAIL random_lockstep cyc %0d got %h exp %h", i, got_v, exp_v);
      end
`ifdef TAPE_MONITOR_EN
      tests_run++;
      if (monitor !== m_mon) begin
        tests_failed++;
        $display("FAIL random_monitor cyc %0d got %h exp %h", i, monitor, m_mon);
      end
`endif
      if (hold == 0) begin
        r = int'($urandom_range(0, 99));
        if (r < 3) adc_act = ~adc_act;
        else if (r < 6) invert = ~invert;
        else adc_in = ~adc_in;
        hold = int'($urandom_range(1, 30));
      end else begin
        hold--;
      end
    end
  endtask

  task automatic test_reset_midrun();
    adc_act = 1'b1; adc_in = 1'b0; invert = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) adc_in = ~adc_in;
      repeat (40) begin
        @(negedge clock);
        tests_run++;
        if (got_v !== exp_v) begin
          tests_failed++;
          $display("FAIL midrun_lockstep got %h exp %h", got_v, exp_v);
        end
      end
    end
    tests_run++;
    if (active !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrun_active got %b exp 1", active);
    end
    #2 reset_osd = 1'b0;
    #1;
    tests_run++;
    if (got_v !== 21'd0) begin
      tests_failed++;
      $display("FAIL midrun_reset got %h exp %h", got_v, 21'd0);
    end
    @(negedge clock);
    reset_osd = 1'b1;
    repeat (20) begin
      @(negedge clock);
      tests_run++;
      if (got_v !== exp_v || active !== 1'b0) begin
        tests_failed++;
        $display("FAIL midrun_release got %h exp %h", got_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arm_edge();
    test_square();
    test_glitch();
    test_idle();
    test_act_drop();
    test_invert();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
